// File: rtl/lru_age_tracker.sv
// -----------------------------------------------------------------------------
// lru_age_tracker
//   True-LRU replacement state for a set-associative cache. Each set keeps one
//   age per way (0 = most recently used, WAYS-1 = least recently used) plus a
//   valid bit. The ages of a set always form a permutation of 0..WAYS-1.
//   A hit promotes the hit way to MRU. A miss picks a victim: the lowest-index
//   invalid way, or the LRU way when every way is valid. The victim is then
//   promoted and marked valid. A flush re-initialises every set, one set per
//   cycle.
//
// Parameters
//   WAYS  associativity (power of two, 2..8)
//   SETS  number of sets (power of two, 2..256)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   flush       one-cycle pulse, starts re-initialisation of all sets
//   req_valid   access request present
//   req_ready   request can be accepted this cycle
//   req_set     set index of the access
//   req_hit     1 = hit on req_way, 0 = miss (fill the victim)
//   req_way     way that hit (ignored on a miss)
//   resp_valid  one-cycle response strobe, one cycle after acceptance
//   resp_way    way that was updated (hit way or victim)
//   resp_evict  the miss replaced a valid line
// -----------------------------------------------------------------------------
module lru_age_tracker #(
  parameter  int WAYS = 4,
  parameter  int SETS = 16,
  localparam int AW   = $clog2(WAYS),
  localparam int SW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] req_set,
  input  logic          req_hit,
  input  logic [AW-1:0] req_way,
  output logic          resp_valid,
  output logic [AW-1:0] resp_way,
  output logic          resp_evict
);

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     init_cnt_q;

  logic [AW-1:0]     age_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];

  logic [AW-1:0]     cur_age [WAYS];
  logic [WAYS-1:0]   cur_valid;
  logic [AW-1:0]     victim;
  logic [AW-1:0]     upd_way;
  logic [AW-1:0]     old_age;
  logic [AW-1:0]     new_age [WAYS];
  logic [WAYS-1:0]   new_valid;
  logic              evict;
  logic              accept;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. A flush always (re)starts INIT, including during INIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (flush) state_d = INIT;
      INIT: if (!flush && init_cnt_q == SW'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Flush drops ready in the same cycle so it beats a request.
  always_comb begin
    req_ready = (state_q == IDLE) && !flush;
  end

  assign accept = req_valid && req_ready;

  // INIT set counter. It wraps to 0 on its own after SETS-1 because SETS is a
  // power of two, so it is already 0 whenever INIT is entered from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  init_cnt_q <= '0;
    else if (flush)           init_cnt_q <= '0;
    else if (state_q == INIT) init_cnt_q <= init_cnt_q + SW'(1);
  end

  // ---------------------------------------------------------------------------
  // Lookup and update of the addressed set
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    cur_valid = valid_q[req_set];
    for (int w = 0; w < WAYS; w++) cur_age[w] = age_q[req_set][w];

    // LRU way first, then overridden by the lowest-index invalid way.
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (cur_age[w] == AW'(WAYS - 1)) victim = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!cur_valid[w]) victim = AW'(w);

    upd_way = req_hit ? req_way : victim;
    old_age = cur_age[upd_way];

    // Promote the updated way; ways younger than it age by one. Ways already
    // older keep their age, which preserves the permutation.
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == upd_way)        new_age[w] = '0;
      else if (cur_age[w] < old_age) new_age[w] = cur_age[w] + AW'(1);
      else                           new_age[w] = cur_age[w];
    end

    new_valid = cur_valid;
    if (!req_hit) new_valid[upd_way] = 1'b1;

    evict = !req_hit && cur_valid[victim];
  end

  // ---------------------------------------------------------------------------
  // Age / valid storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset asynchronously as a whole (it is flops, not a
  // RAM), so the tracker is usable on the first edge after reset with no INIT
  // pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
        valid_q[s] <= '0;
      end
    end else if (state_q == INIT) begin
      for (int w = 0; w < WAYS; w++) age_q[init_cnt_q][w] <= AW'(w);
      valid_q[init_cnt_q] <= '0;
    end else if (accept) begin
      for (int w = 0; w < WAYS; w++) age_q[req_set][w] <= new_age[w];
      valid_q[req_set] <= new_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered response, one cycle after acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_way   <= '0;
      resp_evict <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_evict <= accept && evict;
      if (accept) resp_way <= upd_way;
    end
  end

endmodule

// File: tb/tb_lru_age_tracker.sv
// -----------------------------------------------------------------------------
// tb_lru_age_tracker
//   Self-checking bench for lru_age_tracker. Three instances: WAYS=4/SETS=16
//   for the directed scenarios, WAYS=2/SETS=4 and WAYS=8/SETS=8 for random
//   traffic against a recency-list reference model (MRU at the front).
// -----------------------------------------------------------------------------
module tb_lru_age_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // WAYS=4, SETS=16
  logic       flush_4 = 0, v_4 = 0, hit_4 = 0;
  logic [3:0] set_4 = 0;
  logic [1:0] way_4 = 0;
  logic       rdy_4, rv_4, re_4;
  logic [1:0] rw_4;
  // WAYS=2, SETS=4
  logic       flush_2 = 0, v_2 = 0, hit_2 = 0;
  logic [1:0] set_2 = 0;
  logic [0:0] way_2 = 0;
  logic       rdy_2, rv_2, re_2;
  logic [0:0] rw_2;
  // WAYS=8, SETS=8
  logic       flush_8 = 0, v_8 = 0, hit_8 = 0;
  logic [2:0] set_8 = 0;
  logic [2:0] way_8 = 0;
  logic       rdy_8, rv_8, re_8;
  logic [2:0] rw_8;

  lru_age_tracker #(.WAYS(4), .SETS(16)) dut4 (
    .clk(clk), .rst(rst), .flush(flush_4), .req_valid(v_4), .req_ready(rdy_4),
    .req_set(set_4), .req_hit(hit_4), .req_way(way_4),
    .resp_valid(rv_4), .resp_way(rw_4), .resp_evict(re_4));

  lru_age_tracker #(.WAYS(2), .SETS(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush_2), .req_valid(v_2), .req_ready(rdy_2),
    .req_set(set_2), .req_hit(hit_2), .req_way(way_2),
    .resp_valid(rv_2), .resp_way(rw_2), .resp_evict(re_2));

  lru_age_tracker #(.WAYS(8), .SETS(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush_8), .req_valid(v_8), .req_ready(rdy_8),
    .req_set(set_8), .req_hit(hit_8), .req_way(way_8),
    .resp_valid(rv_8), .resp_way(rw_8), .resp_evict(re_8));

  // ---------------------------------------------------------------------------
  // Observation helpers (instance selected by its WAYS value)
  // ---------------------------------------------------------------------------
  function automatic int get_age(int which, int s, int w);
    case (which)
      2:       return int'(dut2.age_q[s][w]);
      8:       return int'(dut8.age_q[s][w]);
      default: return int'(dut4.age_q[s][w]);
    endcase
  endfunction

  function automatic int get_valid(int which, int s, int w);
    case (which)
      2:       return int'(dut2.valid_q[s][w]);
      8:       return int'(dut8.valid_q[s][w]);
      default: return int'(dut4.valid_q[s][w]);
    endcase
  endfunction

  function automatic int get_rv(int which);
    case (which)
      2: return int'(rv_2); 8: return int'(rv_8); default: return int'(rv_4);
    endcase
  endfunction

  function automatic int get_rw(int which);
    case (which)
      2: return int'(rw_2); 8: return int'(rw_8); default: return int'(rw_4);
    endcase
  endfunction

  function automatic int get_re(int which);
    case (which)
      2: return int'(re_2); 8: return int'(re_8); default: return int'(re_4);
    endcase
  endfunction

  function automatic int get_rdy(int which);
    case (which)
      2: return int'(rdy_2); 8: return int'(rdy_8); default: return int'(rdy_4);
    endcase
  endfunction

  task automatic drive(int which, bit v, int s, bit h, int w);
    case (which)
      2: begin v_2 = v; set_2 = 2'(s); hit_2 = h; way_2 = 1'(w); end
      8: begin v_8 = v; set_8 = 3'(s); hit_8 = h; way_8 = 3'(w); end
      default: begin v_4 = v; set_4 = 4'(s); hit_4 = h; way_4 = 2'(w); end
    endcase
  endtask

  // Packs a WAYS=4 set's ages as {age0,age1,age2,age3} for compact comparison.
  function automatic logic [15:0] ages4(int s);
    logic [15:0] r = '0;
    for (int w = 0; w < 4; w++) r = {r[11:0], 4'(get_age(4, s, w))};
    return r;
  endfunction

  // Counts cycles with req_ready low on dut4, starting at the current negedge.
  task automatic count_init(output int cnt);
    cnt = 0;
    while (rdy_4 === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int bad_sets;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (rdy_4 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", rdy_4); end
    n_cmp++; if ({rv_4, rw_4, re_4} !== 4'b0) begin n_bad++; $display("FAIL reset_resp got=%b want=0000", {rv_4, rw_4, re_4}); end
    bad_sets = 0;
    for (int s = 0; s < 16; s++) begin
      if (ages4(s) !== 16'h0123) bad_sets++;
      for (int w = 0; w < 4; w++) if (get_valid(4, s, w) != 0) bad_sets++;
    end
    n_cmp++; if (bad_sets != 0) begin n_bad++; $display("FAIL reset_state bad_entries=%0d want=0", bad_sets); end
    rst = 1'b0;
  endtask

  // Issue one request on dut4 and check its response one cycle later.
  task automatic issue_check4(string name, int s, bit h, int w, int exp_way, int exp_ev);
    @(negedge clk);
    n_cmp++; if (rdy_4 !== 1'b1) begin n_bad++; $display("FAIL %s_ready got=%b want=1", name, rdy_4); end
    drive(4, 1, s, h, w);
    @(negedge clk);
    drive(4, 0, 0, 0, 0);
    n_cmp++;
    if (rv_4 !== 1'b1 || int'(rw_4) != exp_way || int'(re_4) != exp_ev) begin
      n_bad++;
      $display("FAIL %s got valid=%b way=%0d evict=%b want valid=1 way=%0d evict=%0d",
               name, rv_4, rw_4, re_4, exp_way, exp_ev);
    end
  endtask

  task automatic test_fill_and_hit();
    for (int i = 0; i < 4; i++) issue_check4($sformatf("fill%0d", i), 3, 0, 0, i, 0);
    n_cmp++; if (ages4(3) !== 16'h3210) begin n_bad++; $display("FAIL fill_ages got=%h want=3210", ages4(3)); end
    issue_check4("hit_way1", 3, 1, 1, 1, 0);
    n_cmp++; if (ages4(3) !== 16'h3021) begin n_bad++; $display("FAIL hit_ages got=%h want=3021", ages4(3)); end
    issue_check4("evict_miss", 3, 0, 0, 0, 1);
    n_cmp++; if (ages4(3) !== 16'h0132) begin n_bad++; $display("FAIL evict_ages got=%h want=0132", ages4(3)); end
    n_cmp++; if (ages4(4) !== 16'h0123) begin n_bad++; $display("FAIL other_set_ages got=%h want=0123", ages4(4)); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(4, 1, 3, 1, 2);
    @(negedge clk);
    n_cmp++; if (rv_4 !== 1'b1 || rw_4 !== 2'd2) begin n_bad++; $display("FAIL b2b_first got valid=%b way=%0d want valid=1 way=2", rv_4, rw_4); end
    drive(4, 1, 3, 1, 0);
    @(negedge clk);
    n_cmp++; if (rv_4 !== 1'b1 || rw_4 !== 2'd0) begin n_bad++; $display("FAIL b2b_second got valid=%b way=%0d want valid=1 way=0", rv_4, rw_4); end
    drive(4, 0, 0, 0, 0);
    n_cmp++; if (ages4(3) !== 16'h0213) begin n_bad++; $display("FAIL b2b_ages got=%h want=0213", ages4(3)); end
    @(negedge clk);
    n_cmp++; if (rv_4 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_resp got=%b want=0", rv_4); end
  endtask

  task automatic test_mru_hit();
    issue_check4("mru_hit", 3, 1, 0, 0, 0);
    n_cmp++; if (ages4(3) !== 16'h0213) begin n_bad++; $display("FAIL mru_ages got=%h want=0213", ages4(3)); end
  endtask

  task automatic test_flush();
    int cnt, bad;
    @(negedge clk);
    drive(4, 1, 5, 0, 0);              // accepted, response lands in the flush cycle
    @(negedge clk);
    n_cmp++; if (rv_4 !== 1'b1 || rw_4 !== 2'd0) begin n_bad++; $display("FAIL pending_resp got valid=%b way=%0d want valid=1 way=0", rv_4, rw_4); end
    drive(4, 1, 6, 0, 0);
    flush_4 = 1'b1;
    #1;
    n_cmp++; if (rdy_4 !== 1'b0) begin n_bad++; $display("FAIL flush_ready_comb got=%b want=0", rdy_4); end
    @(negedge clk);
    flush_4 = 1'b0;
    drive(4, 0, 0, 0, 0);
    n_cmp++; if (rv_4 !== 1'b0) begin n_bad++; $display("FAIL flush_blocks_req got=%b want=0", rv_4); end
    count_init(cnt);
    n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL init_length got=%0d want=16", cnt); end
    bad = 0;
    for (int s = 0; s < 16; s++) begin
      if (ages4(s) !== 16'h0123) bad++;
      for (int w = 0; w < 4; w++) if (get_valid(4, s, w) != 0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL flush_state bad_entries=%0d want=0", bad); end

    // A second flush mid-INIT restarts the count from set 0.
    flush_4 = 1'b1;
    @(negedge clk);
    flush_4 = 1'b0;
    repeat (5) @(negedge clk);
    flush_4 = 1'b1;
    @(negedge clk);
    flush_4 = 1'b0;
    count_init(cnt);
    n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL reflush_length got=%0d want=16", cnt); end
  endtask

  task automatic test_rst_mid();
    // Reset in the middle of INIT.
    @(negedge clk);
    flush_4 = 1'b1;
    @(negedge clk);
    flush_4 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rdy_4 !== 1'b0) begin n_bad++; $display("FAIL mid_init_busy got=%b want=0", rdy_4); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rdy_4 !== 1'b1 || rv_4 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_init got ready=%b valid=%b want ready=1 valid=0", rdy_4, rv_4); end
    // Release and issue on the very first edge, then reset mid-response.
    @(negedge clk);
    rst = 1'b0;
    drive(4, 1, 7, 0, 0);
    @(posedge clk);
    #1;
    n_cmp++; if (rv_4 !== 1'b1 || rw_4 !== 2'd0) begin n_bad++; $display("FAIL first_edge_accept got valid=%b way=%0d want valid=1 way=0", rv_4, rw_4); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rv_4 !== 1'b0 || rw_4 !== 2'd0 || re_4 !== 1'b0 || rdy_4 !== 1'b1 || get_valid(4, 7, 0) != 0) begin
      n_bad++;
      $display("FAIL rst_mid_resp got valid=%b way=%0d evict=%b ready=%b v70=%0d want 0 0 0 1 0",
               rv_4, rw_4, re_4, rdy_4, get_valid(4, 7, 0));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (rdy_4 !== 1'b1) begin n_bad++; $display("FAIL ready_after_rst got=%b want=1", rdy_4); end
  endtask

  // Reference model: per set, a recency list of ways with the MRU at the front;
  // a way's age is its position in the list.
  int ord [256][$];
  bit mval[256][8];

  task automatic test_random(int which, int ways, int sets, int n);
    bit pend = 0;
    int exp_w = 0, exp_e = 0;
    int bad_perm, bad_age;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < sets; s++) begin
      ord[s].delete();
      for (int w = 0; w < ways; w++) begin
        ord[s].push_back(w);
        mval[s][w] = 1'b0;
      end
    end
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pend) begin
        if (get_rv(which) != 1 || get_rw(which) != exp_w || get_re(which) != exp_e) begin
          n_bad++;
          $display("FAIL rand_w%0d_resp[%0d] got valid=%0d way=%0d evict=%0d want valid=1 way=%0d evict=%0d",
                   ways, i, get_rv(which), get_rw(which), get_re(which), exp_w, exp_e);
        end
      end else if (get_rv(which) != 0) begin
        n_bad++;
        $display("FAIL rand_w%0d_idle[%0d] got valid=%0d want 0", ways, i, get_rv(which));
      end
      pend = (i < n) && ($urandom_range(0, 9) < 8);
      if (pend) begin
        int s = $urandom_range(0, sets - 1);
        bit h = $urandom_range(0, 1) == 1;
        int w = $urandom_range(0, ways - 1);
        int pos = 0;
        n_cmp++; if (get_rdy(which) != 1) begin n_bad++; $display("FAIL rand_w%0d_ready[%0d] got=%0d want=1", ways, i, get_rdy(which)); end
        if (h) begin
          exp_w = w;
          exp_e = 0;
        end else begin
          exp_w = -1;
          for (int k = 0; k < ways; k++) if (!mval[s][k] && exp_w < 0) exp_w = k;
          if (exp_w < 0) begin
            exp_w = ord[s][ways - 1];
            exp_e = 1;
          end else begin
            exp_e = 0;
          end
          mval[s][exp_w] = 1'b1;
        end
        for (int k = 0; k < ord[s].size(); k++) if (ord[s][k] == exp_w) pos = k;
        ord[s].delete(pos);
        ord[s].push_front(exp_w);
        drive(which, 1, s, h, w);
      end else begin
        drive(which, 0, 0, 0, 0);
      end
    end
    bad_perm = 0;
    bad_age = 0;
    for (int s = 0; s < sets; s++) begin
      bit [7:0] seen = '0;
      for (int w = 0; w < ways; w++) begin
        int a = get_age(which, s, w);
        if (a < ways) seen[a] = 1'b1;
        if (a != ord[s].find_first_index(x) with (x == w)[0]) bad_age++;
        if (get_valid(which, s, w) != int'(mval[s][w])) bad_age++;
      end
      if (seen != 8'((1 << ways) - 1)) bad_perm++;
    end
    n_cmp++; if (bad_perm != 0) begin n_bad++; $display("FAIL rand_w%0d_perm bad_sets=%0d want=0", ways, bad_perm); end
    n_cmp++; if (bad_age != 0) begin n_bad++; $display("FAIL rand_w%0d_state bad_entries=%0d want=0", ways, bad_age); end
  endtask

  initial begin
    test_reset();
    test_fill_and_hit();
    test_back_to_back();
    test_mru_hit();
    test_flush();
    test_rst_mid();
    test_random(2, 2, 4, 400);
    test_random(8, 8, 8, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog bench did not complete within time limit");
    $fatal(1);
  end

endmodule
